// File: rtl/inv_addkey_mixcol.sv
// ---------------------------------------------------------------------------
// inv_addkey_mixcol
// One AES decryption round tail: AddRoundKey followed by InvMixColumns (the
// latter skipped on the final round). A single column engine is reused for
// four cycles, rewriting the working register one column at a time.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   in_state / in_key / in_last are valid
//   in_ready   block can accept a new input (IDLE only)
//   in_state   128-bit state, column c = [127-32c -: 32], row 0 = MS byte
//   in_key     128-bit round key, same layout
//   in_last    final round: AddRoundKey only
//   out_valid  out_state holds a completed result
//   out_ready  downstream accepts out_state
//   out_state  result, zero whenever out_valid is low
// ---------------------------------------------------------------------------

// Single-column InvMixColumns over GF(2^8), polynomial 0x11B.
module inv_mix_column (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a  [4];
    logic [7:0] w_m9 [4];
    logic [7:0] w_mb [4];
    logic [7:0] w_md [4];
    logic [7:0] w_me [4];

    // Multiples 9, b, d, e built from the 2x/4x/8x doubling chain.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            logic [7:0] w_x2, w_x4, w_x8;
            assign w_a[gi]  = i_col[31-8*gi -: 8];
            assign w_x2     = xtime(w_a[gi]);
            assign w_x4     = xtime(w_x2);
            assign w_x8     = xtime(w_x4);
            assign w_m9[gi] = w_x8 ^ w_a[gi];
            assign w_mb[gi] = w_x8 ^ w_x2 ^ w_a[gi];
            assign w_md[gi] = w_x8 ^ w_x4 ^ w_a[gi];
            assign w_me[gi] = w_x8 ^ w_x4 ^ w_x2;
        end
    endgenerate

    assign o_col[31:24] = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
    assign o_col[23:16] = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
    assign o_col[15:8]  = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
    assign o_col[7:0]   = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];
endmodule

module inv_addkey_mixcol (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [1:0]   r_col;
    logic [127:0] r_work;
    logic [127:0] w_work_mixed;
    logic [31:0]  w_cols [4];
    logic [31:0]  w_col_in;
    logic [31:0]  w_col_out;
    logic         w_fire_in;

    assign w_fire_in = in_valid && (r_state == IDLE);

    // Split the working register into columns; only the column selected by
    // the counter is replaced by the engine result, the rest pass through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign w_cols[gi] = r_work[127-32*gi -: 32];
            assign w_work_mixed[127-32*gi -: 32] =
                (r_col == 2'(gi)) ? w_col_out : w_cols[gi];
        end
    endgenerate

    assign w_col_in = w_cols[r_col];

    inv_mix_column u_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_state    = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_fire_in) begin
                    w_state_next = in_last ? DONE : MIX;
                end
            end
            MIX: begin
                if (r_col == 2'd3) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_state = r_work;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= 2'd0;
            r_work <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fire_in) begin
                        r_work <= in_state ^ in_key;
                        r_col  <= 2'd0;
                    end
                end
                MIX: begin
                    r_work <= w_work_mixed;
                    r_col  <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
